// File: rtl/quadrilatero_pkg.sv
// rtl/quadrilatero_pkg.sv - shared matrix register file types and constants
package quadrilatero_pkg;

    localparam int N_ROWS       = 4;
    localparam int X_ID_WIDTH   = 4;
    localparam int RF_SEQ_DEPTH = 4;

    // One dispatcher token: which kinds of row access the instruction needs.
    typedef struct packed {
        logic                  rvalid;
        logic                  wready;
        logic [X_ID_WIDTH-1:0] id;
    } rw_queue_t;

endpackage

// File: rtl/quadrilatero_reg_queue.sv
// rtl/quadrilatero_reg_queue.sv - one register's token FIFO, head row progress and grant logic
module quadrilatero_reg_queue
    import quadrilatero_pkg::*;
#(
    parameter int N_ROWS   = quadrilatero_pkg::N_ROWS,
    parameter int DEPTH    = RF_SEQ_DEPTH,
    parameter int N_RPORTS = 3,
    localparam int ROW_W   = $clog2(N_ROWS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 push_i,
    input  rw_queue_t                            entry_i,
    output logic                                 full_o,
    input  logic [N_RPORTS-1:0]                  rd_req_i,
    input  logic [N_RPORTS-1:0][ROW_W-1:0]       rd_row_i,
    input  logic [N_RPORTS-1:0][X_ID_WIDTH-1:0]  rd_id_i,
    output logic [N_RPORTS-1:0]                  rd_gnt_o,
    input  logic                                 wr_req_i,
    input  logic [ROW_W-1:0]                     wr_row_i,
    input  logic [X_ID_WIDTH-1:0]                wr_id_i,
    output logic                                 wr_gnt_o,
    output rw_queue_t [N_ROWS-1:0]               scoreboard_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rw_queue_t          mem [DEPTH];
    rw_queue_t          head;
    logic [PTR_W-1:0]   head_ptr, tail_ptr;
    logic [CNT_W-1:0]   count;
    logic [N_ROWS-1:0]  rd_done, wr_done;
    logic [N_ROWS-1:0]  rd_set, wr_set;
    logic [N_ROWS-1:0]  rd_done_next, wr_done_next;
    logic               nonempty, push_acc, pop;

    assign head     = mem[head_ptr];
    assign nonempty = (count != '0);
    assign full_o   = (count == CNT_W'(DEPTH));
    // When full, the slot being vacated by a pop is the one the push lands in.
    assign push_acc = push_i & (~full_o | pop);

    always_comb begin
        rd_gnt_o = '0;
        rd_set   = '0;
        for (int p = 0; p < N_RPORTS; p++) begin
            rd_gnt_o[p] = rd_req_i[p] & nonempty & head.rvalid &
                          (head.id == rd_id_i[p]) & ~rd_done[rd_row_i[p]];
            if (rd_gnt_o[p]) rd_set[rd_row_i[p]] = 1'b1;
        end
    end

    // Accumulate tokens may write a row only once it is read, or read this cycle.
    always_comb begin
        wr_set   = '0;
        wr_gnt_o = wr_req_i & nonempty & head.wready & (head.id == wr_id_i) &
                   ~wr_done[wr_row_i] &
                   (~head.rvalid | rd_done[wr_row_i] | rd_set[wr_row_i]);
        if (wr_gnt_o) wr_set[wr_row_i] = 1'b1;
    end

    assign rd_done_next = rd_done | rd_set;
    assign wr_done_next = wr_done | wr_set;
    assign pop = nonempty & (~head.rvalid | (&rd_done_next)) &
                 (~head.wready | (&wr_done_next));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            rd_done  <= '0;
            wr_done  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_acc) begin
                mem[tail_ptr] <= entry_i;
                tail_ptr      <= tail_ptr + 1'b1;
            end
            if (pop) begin
                head_ptr <= head_ptr + 1'b1;
                rd_done  <= '0;
                wr_done  <= '0;
            end else begin
                rd_done  <= rd_done_next;
                wr_done  <= wr_done_next;
            end
            case ({push_acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_i) begin
            assert (!full_o || pop) else $warning("push to full queue dropped");
            assert (entry_i.rvalid || entry_i.wready) else $warning("token with no access pushed");
        end
    end

    always_comb begin
        for (int k = 0; k < N_ROWS; k++) begin
            scoreboard_o[k].rvalid = nonempty & head.rvalid & ~rd_done[k];
            scoreboard_o[k].wready = nonempty & head.wready & ~wr_done[k];
            scoreboard_o[k].id     = head.id;
        end
    end

endmodule

// File: rtl/quadrilatero_rf_sequencer.sv
// rtl/quadrilatero_rf_sequencer.sv - per-register in-order row access scheduler
module quadrilatero_rf_sequencer
    import quadrilatero_pkg::*;
#(
    parameter int N_REGS   = 8,
    parameter int N_ROWS   = quadrilatero_pkg::N_ROWS,
    parameter int DEPTH    = RF_SEQ_DEPTH,
    parameter int N_RPORTS = 3,
    localparam int REG_W   = $clog2(N_REGS),
    localparam int ROW_W   = $clog2(N_ROWS)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  rw_queue_t [N_REGS-1:0]               rw_queue_entry_i,
    input  logic [N_REGS-1:0]                    rw_queue_push_i,
    output logic [N_REGS-1:0]                    rw_queue_full_o,
    input  logic [N_RPORTS-1:0]                  rd_req_i,
    input  logic [N_RPORTS-1:0][REG_W-1:0]       rd_reg_i,
    input  logic [N_RPORTS-1:0][ROW_W-1:0]       rd_row_i,
    input  logic [N_RPORTS-1:0][X_ID_WIDTH-1:0]  rd_id_i,
    output logic [N_RPORTS-1:0]                  rd_gnt_o,
    input  logic                                 wr_req_i,
    input  logic [REG_W-1:0]                     wr_reg_i,
    input  logic [ROW_W-1:0]                     wr_row_i,
    input  logic [X_ID_WIDTH-1:0]                wr_id_i,
    output logic                                 wr_gnt_o,
    output rw_queue_t [N_REGS-1:0][N_ROWS-1:0]   scoreboard_o
);

    logic [N_REGS-1:0][N_RPORTS-1:0] slice_rd_req, slice_rd_gnt;
    logic [N_REGS-1:0]               slice_wr_req, slice_wr_gnt;

    always_comb begin
        slice_rd_req = '0;
        slice_wr_req = '0;
        for (int r = 0; r < N_REGS; r++) begin
            for (int p = 0; p < N_RPORTS; p++) begin
                slice_rd_req[r][p] = rd_req_i[p] && (rd_reg_i[p] == REG_W'(r));
            end
            slice_wr_req[r] = wr_req_i && (wr_reg_i == REG_W'(r));
        end
    end

    // A port addresses exactly one register, so OR-ing slices recovers its grant.
    always_comb begin
        rd_gnt_o = '0;
        for (int r = 0; r < N_REGS; r++) rd_gnt_o = rd_gnt_o | slice_rd_gnt[r];
    end

    assign wr_gnt_o = |slice_wr_gnt;

    for (genvar r = 0; r < N_REGS; r++) begin : g_reg
        quadrilatero_reg_queue #(
            .N_ROWS   (N_ROWS),
            .DEPTH    (DEPTH),
            .N_RPORTS (N_RPORTS)
        ) u_queue (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .push_i       (rw_queue_push_i[r]),
            .entry_i      (rw_queue_entry_i[r]),
            .full_o       (rw_queue_full_o[r]),
            .rd_req_i     (slice_rd_req[r]),
            .rd_row_i     (rd_row_i),
            .rd_id_i      (rd_id_i),
            .rd_gnt_o     (slice_rd_gnt[r]),
            .wr_req_i     (slice_wr_req[r]),
            .wr_row_i     (wr_row_i),
            .wr_id_i      (wr_id_i),
            .wr_gnt_o     (slice_wr_gnt[r]),
            .scoreboard_o (scoreboard_o[r])
        );
    end

endmodule
